write_path_arbiter: RTL and testbench

WRITE_PATH_ARBITER -- requirements
Module: write_path_arbiter

---
 rtl/write_path_arbiter.sv | 146 ++++++++++++++
 tb/tb_write_path_arbiter.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/write_path_arbiter.sv
// Three-way round-robin arbiter for a shared downstream write port. An owner is
// locked for BURST_BEATS data beats, and the address command is issued on beat 0.

module wpa_port (
    input  logic is_owner,
    input  logic stall,
    input  logic af_wr_en,
    input  logic wdf_wr_en,
    output logic req,
    output logic af_full,
    output logic wdf_full
);
    assign req      = af_wr_en | wdf_wr_en;
    // Non-owners are always held off. The owner sees the downstream stall.
    assign af_full  = !is_owner | stall;
    assign wdf_full = !is_owner | stall;
endmodule

module write_path_arbiter #(
    parameter int BURST_BEATS = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [30:0]  filler_addr_din,
    input  logic         filler_af_wr_en,
    input  logic [127:0] filler_wdf_din,
    input  logic [15:0]  filler_wdf_mask_din,
    input  logic         filler_wdf_wr_en,
    output logic         filler_af_full,
    output logic         filler_wdf_full,
    input  logic [30:0]  line_addr_din,
    input  logic         line_af_wr_en,
    input  logic [127:0] line_wdf_din,
    input  logic [15:0]  line_wdf_mask_din,
    input  logic         line_wdf_wr_en,
    output logic         line_af_full,
    output logic         line_wdf_full,
    input  logic [30:0]  bypass_addr_din,
    input  logic         bypass_af_wr_en,
    input  logic [127:0] bypass_wdf_din,
    input  logic [15:0]  bypass_wdf_mask_din,
    input  logic         bypass_wdf_wr_en,
    output logic         bypass_af_full,
    output logic         bypass_wdf_full,
    input  logic         af_full,
    input  logic         wdf_full,
    output logic [30:0]  addr_din,
    output logic [2:0]   af_cmd_din,
    output logic         af_wr_en,
    output logic [127:0] wdf_din,
    output logic [15:0]  wdf_mask_din,
    output logic         wdf_wr_en,
    output logic [1:0]   grant,
    output logic         busy,
    output logic [15:0]  bursts_done
);
    localparam int NUM_REQ = 3;
    localparam logic [1:0] LAST_BEAT = 2'(BURST_BEATS - 1);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t     state;
    logic [1:0] beat, rr_ptr, owner, sel;
    logic       stall, last;

    logic [NUM_REQ-1:0][30:0]  req_addr;
    logic [NUM_REQ-1:0][127:0] req_data;
    logic [NUM_REQ-1:0][15:0]  req_mask;
    logic [NUM_REQ-1:0]        req_af, req_wdf, req, port_af_full, port_wdf_full;

    assign req_addr = {bypass_addr_din, line_addr_din, filler_addr_din};
    assign req_data = {bypass_wdf_din, line_wdf_din, filler_wdf_din};
    assign req_mask = {bypass_wdf_mask_din, line_wdf_mask_din, filler_wdf_mask_din};
    assign req_af   = {bypass_af_wr_en, line_af_wr_en, filler_af_wr_en};
    assign req_wdf  = {bypass_wdf_wr_en, line_wdf_wr_en, filler_wdf_wr_en};

    assign stall = af_full | wdf_full;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_port
        wpa_port u_port (
            .is_owner (grant == 2'(g)),
            .stall    (stall),
            .af_wr_en (req_af[g]),
            .wdf_wr_en(req_wdf[g]),
            .req      (req[g]),
            .af_full  (port_af_full[g]),
            .wdf_full (port_wdf_full[g])
        );
    end

    assign filler_af_full  = port_af_full[0];
    assign filler_wdf_full = port_wdf_full[0];
    assign line_af_full    = port_af_full[1];
    assign line_wdf_full   = port_wdf_full[1];
    assign bypass_af_full  = port_af_full[2];
    assign bypass_wdf_full = port_wdf_full[2];

    // Scanning downward lets the nearest requester to rr_ptr overwrite farther ones.
    always_comb begin
        logic [1:0] idx;
        idx   = 2'd0;
        grant = 2'd3;
        if (rst) begin
            if (state == LOCKED) begin
                grant = owner;
            end else begin
                for (int i = NUM_REQ - 1; i >= 0; i--) begin
                    idx = 2'((int'(rr_ptr) + i) % NUM_REQ);
                    if (req[idx]) grant = idx;
                end
            end
        end
    end

    assign sel          = (grant == 2'd3) ? 2'd0 : grant;
    assign addr_din     = req_addr[sel];
    assign wdf_din      = req_data[sel];
    assign wdf_mask_din = req_mask[sel];
    assign af_cmd_din   = 3'b000;
    assign af_wr_en     = (grant != 2'd3) && req_af[sel] && (beat == 2'd0) && !stall;
    assign wdf_wr_en    = (grant != 2'd3) && req_wdf[sel] && !stall;
    assign busy         = (state == LOCKED);

    assign last = (state == IDLE) ? (BURST_BEATS == 1) : (beat == LAST_BEAT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            beat        <= 2'd0;
            rr_ptr      <= 2'd0;
            owner       <= 2'd0;
            bursts_done <= 16'd0;
        end else if (wdf_wr_en) begin
            if (last) begin
                state       <= IDLE;
                beat        <= 2'd0;
                rr_ptr      <= (grant == 2'd2) ? 2'd0 : grant + 2'd1;
                bursts_done <= bursts_done + 16'd1;
            end else begin
                state <= LOCKED;
                owner <= grant;
                beat  <= beat + 2'd1;
            end
        end
    end
endmodule

// File: tb/tb_write_path_arbiter.sv
// Self-checking bench for write_path_arbiter. It runs directed scenarios plus randomized
// traffic against a burst-level reference model, and runs a BURST_BEATS=1 instance for the counter wrap.

module tb_write_path_arbiter;
    localparam int BB = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [30:0]  r_addr [3];
    logic         r_af   [3];
    logic [127:0] r_data [3];
    logic [15:0]  r_mask [3];
    logic         r_wdf  [3];
    logic         r_aff  [3];
    logic         r_wff  [3];
    logic         af_full, wdf_full;
    logic [30:0]  addr_din;
    logic [2:0]   af_cmd_din;
    logic         af_wr_en, wdf_wr_en, busy;
    logic [127:0] wdf_din;
    logic [15:0]  wdf_mask_din, bursts_done;
    logic [1:0]   grant;
    logic [5:0]   fulls;

    assign fulls = {r_aff[2], r_wff[2], r_aff[1], r_wff[1], r_aff[0], r_wff[0]};

    write_path_arbiter #(.BURST_BEATS(BB)) dut (
        .clk(clk), .rst(rst),
        .filler_addr_din(r_addr[0]), .filler_af_wr_en(r_af[0]), .filler_wdf_din(r_data[0]),
        .filler_wdf_mask_din(r_mask[0]), .filler_wdf_wr_en(r_wdf[0]),
        .filler_af_full(r_aff[0]), .filler_wdf_full(r_wff[0]),
        .line_addr_din(r_addr[1]), .line_af_wr_en(r_af[1]), .line_wdf_din(r_data[1]),
        .line_wdf_mask_din(r_mask[1]), .line_wdf_wr_en(r_wdf[1]),
        .line_af_full(r_aff[1]), .line_wdf_full(r_wff[1]),
        .bypass_addr_din(r_addr[2]), .bypass_af_wr_en(r_af[2]), .bypass_wdf_din(r_data[2]),
        .bypass_wdf_mask_din(r_mask[2]), .bypass_wdf_wr_en(r_wdf[2]),
        .bypass_af_full(r_aff[2]), .bypass_wdf_full(r_wff[2]),
        .af_full(af_full), .wdf_full(wdf_full),
        .addr_din(addr_din), .af_cmd_din(af_cmd_din), .af_wr_en(af_wr_en),
        .wdf_din(wdf_din), .wdf_mask_din(wdf_mask_din), .wdf_wr_en(wdf_wr_en),
        .grant(grant), .busy(busy), .bursts_done(bursts_done)
    );

    // Single-beat instance, used for the bursts_done wrap
    logic         w1_rst = 1'b0;
    logic         w1_req = 1'b0;
    logic [30:0]  w1_addr;
    logic [2:0]   w1_cmd;
    logic         w1_af_wr_en, w1_wdf_wr_en, w1_busy;
    logic [127:0] w1_din;
    logic [15:0]  w1_mask, w1_done;
    logic [1:0]   w1_grant;
    logic         w1_f_aff, w1_f_wff, w1_l_aff, w1_l_wff, w1_b_aff, w1_b_wff;

    write_path_arbiter #(.BURST_BEATS(1)) dut_w1 (
        .clk(clk), .rst(w1_rst),
        .filler_addr_din(31'h0), .filler_af_wr_en(w1_req), .filler_wdf_din(128'h0),
        .filler_wdf_mask_din(16'h0), .filler_wdf_wr_en(w1_req),
        .filler_af_full(w1_f_aff), .filler_wdf_full(w1_f_wff),
        .line_addr_din(31'h0), .line_af_wr_en(1'b0), .line_wdf_din(128'h0),
        .line_wdf_mask_din(16'h0), .line_wdf_wr_en(1'b0),
        .line_af_full(w1_l_aff), .line_wdf_full(w1_l_wff),
        .bypass_addr_din(31'h0), .bypass_af_wr_en(1'b0), .bypass_wdf_din(128'h0),
        .bypass_wdf_mask_din(16'h0), .bypass_wdf_wr_en(1'b0),
        .bypass_af_full(w1_b_aff), .bypass_wdf_full(w1_b_wff),
        .af_full(1'b0), .wdf_full(1'b0),
        .addr_din(w1_addr), .af_cmd_din(w1_cmd), .af_wr_en(w1_af_wr_en),
        .wdf_din(w1_din), .wdf_mask_din(w1_mask), .wdf_wr_en(w1_wdf_wr_en),
        .grant(w1_grant), .busy(w1_busy), .bursts_done(w1_done)
    );

    int checks = 0;
    int failures = 0;
    logic [15:0] exp_done = 16'd0;

    task automatic idle_inputs();
        for (int r = 0; r < 3; r++) begin
            r_af[r] = 1'b0; r_wdf[r] = 1'b0; r_addr[r] = '0; r_data[r] = '0; r_mask[r] = '0;
        end
        af_full = 1'b0; wdf_full = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b0;
        #2 rst = 1'b1;
        exp_done = 16'd0;
    endtask

    task automatic test_reset();
        idle_inputs();
        for (int r = 0; r < 3; r++) begin r_af[r] = 1'b1; r_wdf[r] = 1'b1; end
        @(negedge clk); #1;
        checks++;
        if ({grant, busy, af_wr_en, wdf_wr_en} !== {2'd3, 1'b0, 1'b0, 1'b0}) begin
            failures++; $display("FAIL reset_outputs: got %b expected %b", {grant, busy, af_wr_en, wdf_wr_en}, 5'b11000);
        end
        checks++;
        if (fulls !== 6'h3f) begin failures++; $display("FAIL reset_fulls: got %b expected 111111", fulls); end
        checks++;
        if (bursts_done !== 16'd0) begin failures++; $display("FAIL reset_count: got %0h expected 0", bursts_done); end
        @(negedge clk);
        idle_inputs();
        rst = 1'b1;
    endtask

    task automatic test_single_burst();
        @(negedge clk);
        r_af[0] = 1'b1; r_wdf[0] = 1'b1; r_addr[0] = 31'h100; r_data[0] = 128'hA0A0; r_mask[0] = 16'h00F0;
        #1;
        checks++;
        if ({grant, af_wr_en, wdf_wr_en, addr_din, wdf_din, wdf_mask_din} !== {2'd0, 1'b1, 1'b1, 31'h100, 128'hA0A0, 16'h00F0}) begin
            failures++; $display("FAIL single_beat0: got grant=%0d af=%b wdf=%b addr=%0h data=%0h mask=%0h expected 0 1 1 100 a0a0 f0",
                grant, af_wr_en, wdf_wr_en, addr_din, wdf_din, wdf_mask_din);
        end
        checks++;
        if (fulls !== 6'b111100) begin failures++; $display("FAIL single_fulls: got %b expected 111100", fulls); end
        @(negedge clk);
        r_af[0] = 1'b0; r_data[0] = 128'hB1B1;
        #1;
        checks++;
        if ({grant, busy, af_wr_en, wdf_wr_en, wdf_din} !== {2'd0, 1'b1, 1'b0, 1'b1, 128'hB1B1}) begin
            failures++; $display("FAIL single_beat1: got grant=%0d busy=%b af=%b wdf=%b data=%0h expected 0 1 0 1 b1b1",
                grant, busy, af_wr_en, wdf_wr_en, wdf_din);
        end
        @(negedge clk);
        idle_inputs();
        exp_done = exp_done + 16'd1;
        #1;
        checks++;
        if ({grant, busy, bursts_done} !== {2'd3, 1'b0, exp_done}) begin
            failures++; $display("FAIL single_done: got grant=%0d busy=%b done=%0h expected 3 0 %0h", grant, busy, bursts_done, exp_done);
        end
        // rr_ptr should now favour line over filler
        r_af[0] = 1'b1; r_wdf[0] = 1'b1; r_af[1] = 1'b1; r_wdf[1] = 1'b1;
        #1;
        checks++;
        if (grant !== 2'd1) begin failures++; $display("FAIL single_rrptr: got grant=%0d expected 1", grant); end
        idle_inputs();
    endtask

    task automatic test_round_robin();
        pulse_reset();
        for (int r = 0; r < 3; r++) begin r_af[r] = 1'b1; r_wdf[r] = 1'b1; end
        for (int k = 0; k < 6; k++) begin
            #1;
            checks++;
            if ({grant, busy, af_wr_en, wdf_wr_en} !== {2'(k % 3), 1'b0, 1'b1, 1'b1}) begin
                failures++; $display("FAIL rr_beat0_%0d: got grant=%0d busy=%b af=%b wdf=%b expected %0d 0 1 1", k, grant, busy, af_wr_en, wdf_wr_en, k % 3);
            end
            @(negedge clk); #1;
            checks++;
            if ({grant, busy, af_wr_en, wdf_wr_en} !== {2'(k % 3), 1'b1, 1'b0, 1'b1}) begin
                failures++; $display("FAIL rr_beat1_%0d: got grant=%0d busy=%b af=%b wdf=%b expected %0d 1 0 1", k, grant, busy, af_wr_en, wdf_wr_en, k % 3);
            end
            @(negedge clk);
            exp_done = exp_done + 16'd1;
        end
        #1;
        checks++;
        if (bursts_done !== 16'd6) begin failures++; $display("FAIL rr_count: got %0d expected 6", bursts_done); end
        idle_inputs();
    endtask

    task automatic test_handoff();
        @(negedge clk);
        r_af[1] = 1'b1; r_wdf[1] = 1'b1;
        #1;
        checks++;
        if (grant !== 2'd1) begin failures++; $display("FAIL handoff_grant_line: got %0d expected 1", grant); end
        @(negedge clk);
        r_af[1] = 1'b0; r_wdf[1] = 1'b0; r_af[2] = 1'b1; r_wdf[2] = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if ({grant, busy, wdf_wr_en, r_aff[2], r_wff[2], r_aff[1]} !== {2'd1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0}) begin
                failures++; $display("FAIL handoff_hold_%0d: got grant=%0d busy=%b wdf=%b byp_full=%b%b line_full=%b expected 1 1 0 11 0",
                    c, grant, busy, wdf_wr_en, r_aff[2], r_wff[2], r_aff[1]);
            end
            @(negedge clk);
        end
        r_wdf[1] = 1'b1;
        #1;
        checks++;
        if ({grant, wdf_wr_en, r_aff[2], r_wff[2]} !== {2'd1, 1'b1, 1'b1, 1'b1}) begin
            failures++; $display("FAIL handoff_last: got grant=%0d wdf=%b byp_full=%b%b expected 1 1 11", grant, wdf_wr_en, r_aff[2], r_wff[2]);
        end
        @(negedge clk);
        r_wdf[1] = 1'b0;
        exp_done = exp_done + 16'd1;
        #1;
        checks++;
        if ({grant, busy, r_aff[2], r_wff[2]} !== {2'd2, 1'b0, 1'b0, 1'b0}) begin
            failures++; $display("FAIL handoff_bypass: got grant=%0d busy=%b byp_full=%b%b expected 2 0 00", grant, busy, r_aff[2], r_wff[2]);
        end
        idle_inputs();
    endtask

    task automatic test_stall();
        @(negedge clk);
        r_af[0] = 1'b1; r_wdf[0] = 1'b1;
        #1;
        checks++;
        if ({grant, af_wr_en} !== {2'd0, 1'b1}) begin failures++; $display("FAIL stall_start: got grant=%0d af=%b expected 0 1", grant, af_wr_en); end
        @(negedge clk);
        r_af[0] = 1'b0; wdf_full = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++;
            if ({busy, af_wr_en, wdf_wr_en, r_wff[0], r_aff[0]} !== 5'b10011) begin
                failures++; $display("FAIL stall_hold_%0d: got busy=%b af=%b wdf=%b full=%b%b expected 1 0 0 11", c, busy, af_wr_en, wdf_wr_en, r_wff[0], r_aff[0]);
            end
            @(negedge clk);
        end
        wdf_full = 1'b0;
        #1;
        checks++;
        if ({busy, wdf_wr_en, bursts_done} !== {1'b1, 1'b1, exp_done}) begin
            failures++; $display("FAIL stall_release: got busy=%b wdf=%b done=%0h expected 1 1 %0h", busy, wdf_wr_en, bursts_done, exp_done);
        end
        @(negedge clk);
        idle_inputs();
        exp_done = exp_done + 16'd1;
        #1;
        checks++;
        if ({busy, bursts_done} !== {1'b0, exp_done}) begin
            failures++; $display("FAIL stall_done: got busy=%b done=%0h expected 0 %0h", busy, bursts_done, exp_done);
        end
    endtask

    task automatic test_random();
        bit m_locked = 1'b0;
        int m_owner = 0, m_taken = 0, m_ptr = 0, eg, src;
        bit stl, e_af, e_wdf;
        logic [5:0] e_fulls;
        pulse_reset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            for (int r = 0; r < 3; r++) begin
                if (m_locked && r == m_owner) begin
                    r_af[r] = 1'b0; r_wdf[r] = ($urandom % 4) != 0;
                end else begin
                    r_af[r] = ($urandom % 5) < 2; r_wdf[r] = r_af[r];
                end
                r_addr[r] = 31'($urandom); r_mask[r] = 16'($urandom);
                r_data[r] = {$urandom, $urandom, $urandom, $urandom};
            end
            af_full = ($urandom % 6) == 0; wdf_full = ($urandom % 6) == 0;
            #1;
            eg = m_locked ? m_owner : 3;
            if (!m_locked) for (int i = 0; i < 3; i++)
                if (eg == 3 && (r_af[(m_ptr + i) % 3] || r_wdf[(m_ptr + i) % 3])) eg = (m_ptr + i) % 3;
            stl   = af_full || wdf_full;
            src   = (eg == 3) ? 0 : eg;
            e_wdf = (eg != 3) && r_wdf[src] && !stl;
            e_af  = (eg != 3) && r_af[src] && !m_locked && !stl;
            for (int r = 0; r < 3; r++) begin
                e_fulls[2*r]   = (r == eg) ? stl : 1'b1;
                e_fulls[2*r+1] = (r == eg) ? stl : 1'b1;
            end
            checks++;
            if ({grant, busy, af_wr_en, wdf_wr_en, af_cmd_din} !== {2'(eg), m_locked, e_af, e_wdf, 3'b000}) begin
                failures++; $display("FAIL rand_ctrl_%0d: got grant=%0d busy=%b af=%b wdf=%b cmd=%0d expected %0d %b %b %b 0",
                    cyc, grant, busy, af_wr_en, wdf_wr_en, af_cmd_din, eg, m_locked, e_af, e_wdf);
            end
            checks++;
            if ({addr_din, wdf_din, wdf_mask_din} !== {r_addr[src], r_data[src], r_mask[src]}) begin
                failures++; $display("FAIL rand_data_%0d: got addr=%0h mask=%0h expected addr=%0h mask=%0h (src %0d)",
                    cyc, addr_din, wdf_mask_din, r_addr[src], r_mask[src], src);
            end
            checks++;
            if ({fulls, bursts_done} !== {e_fulls, exp_done}) begin
                failures++; $display("FAIL rand_fulls_%0d: got fulls=%b done=%0h expected %b %0h", cyc, fulls, bursts_done, e_fulls, exp_done);
            end
            if (e_wdf) begin
                m_taken++;
                if (m_taken == BB) begin
                    m_locked = 1'b0; m_taken = 0; m_ptr = (eg + 1) % 3; exp_done = exp_done + 16'd1;
                end else begin
                    m_locked = 1'b1; m_owner = eg;
                end
            end
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_async_reset();
        pulse_reset();
        r_af[0] = 1'b1; r_wdf[0] = 1'b1;
        @(negedge clk);
        r_af[0] = 1'b0; r_wdf[0] = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL areset_pre: got busy=%b expected 1", busy); end
        #1 rst = 1'b0;
        #1;
        checks++;
        if ({busy, grant, af_wr_en, wdf_wr_en, bursts_done, fulls} !== {1'b0, 2'd3, 1'b0, 1'b0, 16'd0, 6'h3f}) begin
            failures++; $display("FAIL areset_now: got busy=%b grant=%0d af=%b wdf=%b done=%0h fulls=%b expected 0 3 0 0 0 111111",
                busy, grant, af_wr_en, wdf_wr_en, bursts_done, fulls);
        end
        @(negedge clk);
        rst = 1'b1;
        exp_done = 16'd0;
        @(negedge clk); #1;
        checks++;
        if ({busy, grant, wdf_wr_en, bursts_done} !== {1'b0, 2'd3, 1'b0, 16'd0}) begin
            failures++; $display("FAIL areset_after: got busy=%b grant=%0d wdf=%b done=%0h expected 0 3 0 0", busy, grant, wdf_wr_en, bursts_done);
        end
    endtask

    task automatic test_wrap();
        @(negedge clk);
        w1_rst = 1'b1; w1_req = 1'b1;
        @(negedge clk); #1;
        checks++;
        if ({w1_busy, w1_grant, w1_af_wr_en, w1_done} !== {1'b0, 2'd0, 1'b1, 16'd1}) begin
            failures++; $display("FAIL w1_single_beat: got busy=%b grant=%0d af=%b done=%0h expected 0 0 1 1", w1_busy, w1_grant, w1_af_wr_en, w1_done);
        end
        repeat (65534) @(negedge clk);
        #1;
        checks++;
        if (w1_done !== 16'hFFFF) begin failures++; $display("FAIL w1_preload: got %0h expected ffff", w1_done); end
        @(negedge clk); #1;
        checks++;
        if (w1_done !== 16'h0000) begin failures++; $display("FAIL w1_wrap: got %0h expected 0", w1_done); end
        w1_req = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_burst();
        test_round_robin();
        test_handoff();
        test_stall();
        test_random();
        test_async_reset();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
